// File: rtl/adlatch_rb_pkg.sv
// Shared types for the latch-bank readback block.
// Defining ADLATCH_RB_PARITY_EN adds a trailing even-parity beat to every frame.
package adlatch_rb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAR  = 2'd2
    } rb_state_t;

`ifdef ADLATCH_RB_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // The counter can hold WIDTH, so it never has to wrap.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/adlatch_rb_shifter.sv
// Snapshot register, beat counter and serial output mux for the readback frame.
// The parity beat exists only when ADLATCH_RB_PARITY_EN is defined.
module adlatch_rb_shifter
    import adlatch_rb_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             C,
    input  logic             R,
    input  logic             load,
    input  logic             advance,
    input  rb_state_t        state,
    input  logic [WIDTH-1:0] bank,
    output logic             at_last,
    output logic             so_data,
    output logic             so_last
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            snap <= '0;
            cnt  <= '0;
        end else if (load) begin
            snap <= bank;
            cnt  <= '0;
        end else if (advance) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign shifted = snap >> cnt;
    assign at_last = (cnt == LAST_IDX);

    // Outputs are forced low outside a frame so reset and idle read as 0.
    always_comb begin
        so_data = 1'b0;
        so_last = 1'b0;
        case (state)
            SEND: begin
                so_data = shifted[0];
                so_last = at_last && !PARITY_EN;
            end
            PAR: begin
                so_data = ^snap;
                so_last = 1'b1;
            end
            default: begin
                so_data = 1'b0;
                so_last = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/adlatch_readback.sv
// Capture bank with per-bit reset value and serial LSB-first readback over valid/ready.
// ADLATCH_RB_PARITY_EN appends an even-parity beat after the data beats.
module adlatch_readback
    import adlatch_rb_pkg::*;
#(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    output logic             busy,
    output logic             so_valid,
    input  logic             so_ready,
    output logic             so_data,
    output logic             so_last,
    output logic             done
);

    rb_state_t        state;
    logic [WIDTH-1:0] bank;
    logic             load;
    logic             advance;
    logic             at_last;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            bank <= RESET_VAL;
        end else if (E) begin
            bank <= D;
        end
    end

    assign load    = (state == IDLE) && start;
    assign advance = (state == SEND) && so_valid && so_ready;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state    <= IDLE;
            busy     <= 1'b0;
            so_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SEND;
                        busy     <= 1'b1;
                        so_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (so_ready && at_last) begin
                        if (PARITY_EN) begin
                            state <= PAR;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            so_valid <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (so_ready) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        so_valid <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    so_valid <= 1'b0;
                end
            endcase
        end
    end

    adlatch_rb_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .C       (C),
        .R       (R),
        .load    (load),
        .advance (advance),
        .state   (state),
        .bank    (bank),
        .at_last (at_last),
        .so_data (so_data),
        .so_last (so_last)
    );

endmodule

// File: tb/tb_adlatch_readback.sv
// Bench for adlatch_readback: two instances (reset value 000 and 111) share stimulus
// and are checked each cycle against a beat-list model plus literal frame words.
module tb_adlatch_readback;

`ifdef ADLATCH_RB_PARITY_EN
    localparam int NB = 4;
    localparam logic [7:0] T1_U0 = 8'b0000, T1_U1 = 8'b1111, T3 = 8'b0101, T4 = 8'b0011;
    localparam logic [7:0] T5A = 8'b0110, T5B = 8'b1001;
`else
    localparam int NB = 3;
    localparam logic [7:0] T1_U0 = 8'b000, T1_U1 = 8'b111, T3 = 8'b101, T4 = 8'b011;
    localparam logic [7:0] T5A = 8'b110, T5B = 8'b001;
`endif

    logic       C = 1'b0;
    logic       R = 1'b0;
    logic       E = 1'b0;
    logic [2:0] D = 3'b000;
    logic       start = 1'b0;
    logic       so_ready = 1'b0;
    logic       busy0, valid0, data0, last0, done0;
    logic       busy1, valid1, data1, last1, done1;

    int vectors = 0;
    int miscompares = 0;

    adlatch_readback #(.WIDTH(3), .RESET_VAL(3'b000)) u0 (
        .C(C), .R(R), .E(E), .D(D), .start(start), .busy(busy0), .so_valid(valid0),
        .so_ready(so_ready), .so_data(data0), .so_last(last0), .done(done0));

    adlatch_readback #(.WIDTH(3), .RESET_VAL(3'b111)) u1 (
        .C(C), .R(R), .E(E), .D(D), .start(start), .busy(busy1), .so_valid(valid1),
        .so_ready(so_ready), .so_data(data1), .so_last(last1), .done(done1));

    always #5 C = ~C;

    // Model: bank per instance and the list of beats still owed in the current frame.
    logic [2:0] rv_m     [2] = '{3'b000, 3'b111};
    logic [2:0] bank_m   [2] = '{3'b000, 3'b111};
    logic [7:0] beats_m  [2] = '{8'h00, 8'h00};
    int         left_m   [2] = '{0, 0};
    logic       done_m   [2] = '{1'b0, 1'b0};

    always @(posedge C or posedge R) begin
        for (int i = 0; i < 2; i++) begin
            if (R) begin
                bank_m[i]  = rv_m[i];
                beats_m[i] = 8'h00;
                left_m[i]  = 0;
                done_m[i]  = 1'b0;
            end else begin
                done_m[i] = 1'b0;
                if (left_m[i] != 0 && so_ready) begin
                    beats_m[i] = beats_m[i] >> 1;
                    left_m[i]  = left_m[i] - 1;
                    if (left_m[i] == 0) done_m[i] = 1'b1;
                end else if (left_m[i] == 0 && start) begin
                    beats_m[i] = {5'b00000, bank_m[i]};
                    if (NB == 4) beats_m[i][3] = ^bank_m[i];
                    left_m[i] = NB;
                end
                if (E) bank_m[i] = D;
            end
        end
    end

    always @(negedge C) begin
        logic [4:0] act [2];
        logic [4:0] exp_v;
        act[0] = {busy0, valid0, data0, last0, done0};
        act[1] = {busy1, valid1, data1, last1, done1};
        for (int i = 0; i < 2; i++) begin
            exp_v = {left_m[i] != 0, left_m[i] != 0, (left_m[i] != 0) & beats_m[i][0],
                     left_m[i] == 1, done_m[i]};
            vectors++;
            if (act[i] !== exp_v) begin
                miscompares++;
                $display("FAIL cycle_u%0d t=%0t busy/valid/data/last/done got %b want %b",
                         i, $time, act[i], exp_v);
            end
        end
    end

    // Beats accepted by each instance and done pulses seen, per frame.
    logic [7:0] w0, w1;
    int n0, n1, dn0;

    always @(posedge C) begin
        if (!R && valid0 && so_ready && n0 < 8) begin w0[n0[2:0]] = data0; n0++; end
        if (!R && valid1 && so_ready && n1 < 8) begin w1[n1[2:0]] = data1; n1++; end
    end

    always @(negedge C) if (done0) dn0++;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s got %b want %b", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic clear_obs();
        w0 = 8'h00; w1 = 8'h00; n0 = 0; n1 = 0; dn0 = 0;
    endtask

    task automatic frame(input logic [7:0] rdy_pat, input int npat,
                         input bit mid_cap, input logic [2:0] mid_d);
        bit finished = 1'b0;
        clear_obs();
        start = 1'b1;
        so_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            so_ready = (k < npat) ? rdy_pat[k] : 1'b1;
            if (k == 0 && mid_cap) begin E = 1'b1; D = mid_d; end
            else E = 1'b0;
            tick();
            if (!busy0) begin finished = 1'b1; break; end
        end
        E = 1'b0;
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout busy still %b want 0", busy0);
        end
        tick();
    endtask

    task automatic capture(input logic [2:0] val);
        E = 1'b1; D = val;
        tick();
        E = 1'b0;
    endtask

    task automatic chk_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] edone);
        chk({name, "_u0_word"}, w0, e0);
        chk({name, "_u1_word"}, w1, e1);
        chk({name, "_beats"}, 8'(n0), 8'(NB));
        chk({name, "_done"}, 8'(dn0), edone);
    endtask

    initial begin
        #1 R = 1'b1;
        #1;
        chk("rst_u0_outs", {3'b000, busy0, valid0, data0, last0, done0}, 8'h00);
        chk("rst_u1_outs", {3'b000, busy1, valid1, data1, last1, done1}, 8'h00);
        repeat (2) @(posedge C);
        #1 R = 1'b0;
        tick();

        frame(8'h00, 0, 1'b0, 3'b000);
        chk_frame("t1_reset_val", T1_U0, T1_U1, 8'd1);

        capture(3'b101);
        frame(8'h00, 0, 1'b0, 3'b000);
        chk_frame("t3_cap101", T3, T3, 8'd1);

        capture(3'b011);
        frame(8'b0000_1001, 4, 1'b0, 3'b000);
        chk_frame("t4_ready_toggle", T4, T4, 8'd1);

        capture(3'b110);
        frame(8'h00, 0, 1'b1, 3'b001);
        chk_frame("t5_snapshot", T5A, T5A, 8'd1);
        frame(8'h00, 0, 1'b0, 3'b000);
        chk_frame("t5_next_frame", T5B, T5B, 8'd1);

        clear_obs();
        start = 1'b1; so_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 R = 1'b1;
        #1;
        chk("t6_abort_u0_outs", {3'b000, busy0, valid0, data0, last0, done0}, 8'h00);
        chk("t6_abort_u1_outs", {3'b000, busy1, valid1, data1, last1, done1}, 8'h00);
        @(posedge C);
        #1 R = 1'b0;
        repeat (3) tick();
        chk("t6_no_done", 8'(dn0), 8'd0);
        frame(8'h00, 0, 1'b0, 3'b000);
        chk_frame("t6_restart", T1_U0, T1_U1, 8'd1);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
